// File: rtl/mfp_ahb_dma_master.sv
// mfp_ahb_dma_master: single-channel AHB-lite DMA initiator.
// Copies a block of 32-bit words from src_addr to dst_addr with single NONSEQ word transfers.
// Each word is one read transfer followed by one write transfer through a one-word buffer.
//
// Ports:
//   HCLK, HRESETn           bus clock, asynchronous active-low reset
//   start, src_addr,        control: start pulse latches the addresses and the word count
//   dst_addr, len, abort    abort takes effect at the next word boundary
//   HADDR..HWDATA           registered AHB-lite master outputs (HSIZE/HBURST/HPROT constant)
//   HRDATA, HREADY, HRESP   AHB-lite slave response
//   busy, done, err         status: transfer active, completion pulse, sticky error
//   words_left              remaining word count
module mfp_ahb_dma_master #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic             HMASTLOCK,
    output logic [3:0]       HPROT,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_left
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    typedef enum logic [2:0] {StIdle, StRdA, StRdD, StWrA, StWrD, StFin} state_e;

    state_e           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      buf_q, buf_d;
    logic [31:0]      haddr_q, haddr_d;
    logic [1:0]       htrans_q, htrans_d;
    logic             hwrite_q, hwrite_d;
    logic [31:0]      hwdata_q, hwdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] words_q, words_d;

    // Word alignment is forced, so the low address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        buf_d    = buf_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        words_d  = words_q;

        unique case (state_q)
            StIdle: begin
                htrans_d = TransIdle;
                if (start) begin
                    src_d   = {src_addr[31:2], 2'b00};
                    dst_d   = {dst_addr[31:2], 2'b00};
                    words_d = len;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    if (len == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d  = StRdA;
                        htrans_d = TransNonseq;
                        hwrite_d = 1'b0;
                        haddr_d  = {src_addr[31:2], 2'b00};
                    end
                end
            end
            StRdA: begin
                if (HREADY) begin
                    state_d  = StRdD;
                    htrans_d = TransIdle;
                end
            end
            StRdD: begin
                // An ERROR is acted on in its first cycle, so no NONSEQ overlaps the response.
                if (HRESP) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StFin;
                end else if (HREADY) begin
                    buf_d    = HRDATA;
                    state_d  = StWrA;
                    htrans_d = TransNonseq;
                    hwrite_d = 1'b1;
                    haddr_d  = dst_q;
                end
            end
            StWrA: begin
                if (HREADY) begin
                    state_d  = StWrD;
                    htrans_d = TransIdle;
                    hwdata_d = buf_q;
                end
            end
            StWrD: begin
                if (HRESP) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StFin;
                end else if (HREADY) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    words_d = words_q - LEN_W'(1);
                    if (words_d == '0 || abort) begin
                        done_d  = 1'b1;
                        state_d = StFin;
                    end else begin
                        state_d  = StRdA;
                        htrans_d = TransNonseq;
                        hwrite_d = 1'b0;
                        haddr_d  = src_d;
                    end
                end
            end
            StFin: begin
                // Bus exits raise done on entry; the zero-length path raises it here instead.
                if (done_q) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d  = StIdle;
                htrans_d = TransIdle;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= StIdle;
            src_q    <= '0;
            dst_q    <= '0;
            buf_q    <= '0;
            haddr_q  <= '0;
            htrans_q <= TransIdle;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            buf_q    <= buf_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            words_q  <= words_d;
        end
    end

    assign HADDR      = haddr_q;
    assign HTRANS     = htrans_q;
    assign HWRITE     = hwrite_q;
    assign HWDATA     = hwdata_q;
    assign HSIZE      = 3'b010;
    assign HBURST     = 3'b000;
    assign HMASTLOCK  = 1'b0;
    assign HPROT      = 4'b0011;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_left = words_q;

endmodule

// File: tb/tb_mfp_ahb_dma_master.sv
// tb_mfp_ahb_dma_master: self-checking bench for mfp_ahb_dma_master.
// A behavioural AHB-lite slave with a sparse word memory answers the DUT; each copy is
// checked against the expected transfer list, final memory contents, status and timing.
module tb_mfp_ahb_dma_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        abort;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_left;

    mfp_ahb_dma_master #(.LEN_W(16)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .abort      (abort),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HMASTLOCK  (HMASTLOCK),
        .HPROT      (HPROT),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_left (words_left)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model state.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_addr_q [$];
    bit          exp_wr_q [$];
    int          addr_stall [64];
    int          data_stall [64];
    int          cyc, xfer_idx, dp_idx, ap_stall, dp_stall, err_xfer, err_phase;
    int          stall_total, done_cnt, done_cyc;
    bit          dp_valid, dp_write, ap_active, prev_stall;
    logic [31:0] dp_addr, prev_haddr, prev_hwdata;
    logic [1:0]  prev_htrans;
    logic        prev_hwrite;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    task automatic clear_slave();
        dp_valid = 0; ap_active = 0; prev_stall = 0; err_phase = 0;
        xfer_idx = 0; stall_total = 0; done_cnt = 0; done_cyc = -1;
        exp_addr_q.delete(); exp_wr_q.delete();
    endtask

    // One bus cycle: answer the current DUT outputs, advance past the edge, update the slave.
    task automatic cycle();
        bit          accept, end_dp, err_cyc;
        logic [31:0] acc_addr;
        logic        acc_wr;
        accept = 0; end_dp = 0; err_cyc = 0;
        if (prev_stall) begin
            chk("stall_haddr", HADDR, prev_haddr);
            chk("stall_htrans", 32'(HTRANS), 32'(prev_htrans));
            chk("stall_hwrite", 32'(HWRITE), 32'(prev_hwrite));
            chk("stall_hwdata", HWDATA, prev_hwdata);
        end
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = $urandom;
        if (dp_valid) begin
            chk("dp_htrans_idle", 32'(HTRANS), 32'd0);
            if (dp_idx == err_xfer) begin
                err_cyc = 1;
                HRESP   = 1'b1;
                HREADY  = (err_phase == 1);
                err_phase++;
                if (err_phase == 2) end_dp = 1;
            end else if (dp_stall > 0) begin
                HREADY = 1'b0;
                dp_stall--;
                stall_total++;
            end else begin
                if (dp_write) mem[dp_addr] = HWDATA;
                else HRDATA = rd_mem(dp_addr);
                end_dp = 1;
            end
        end else if (HTRANS == 2'b10) begin
            if (!ap_active) begin
                ap_active = 1;
                ap_stall  = addr_stall[xfer_idx % 64];
            end
            if (ap_stall > 0) begin
                HREADY = 1'b0;
                ap_stall--;
                stall_total++;
            end else begin
                accept = 1;
            end
        end
        acc_addr    = HADDR;
        acc_wr      = HWRITE;
        prev_stall  = !HREADY && !err_cyc;
        prev_haddr  = HADDR;
        prev_htrans = HTRANS;
        prev_hwrite = HWRITE;
        prev_hwdata = HWDATA;
        @(posedge HCLK);
        #1;
        cyc++;
        if (end_dp) dp_valid = 0;
        if (accept) begin
            n_checks++;
            assert (exp_addr_q.size() != 0) else begin
                n_fail++;
                $error("FAIL extra_xfer: observed NONSEQ at 0x%08h expected none", acc_addr);
            end
            if (exp_addr_q.size() != 0) begin
                chk("xfer_addr", acc_addr, exp_addr_q.pop_front());
                chk("xfer_write", 32'(acc_wr), 32'(exp_wr_q.pop_front()));
            end
            dp_valid  = 1;
            dp_addr   = acc_addr;
            dp_write  = acc_wr;
            dp_idx    = xfer_idx;
            dp_stall  = data_stall[xfer_idx % 64];
            err_phase = 0;
            ap_active = 0;
            xfer_idx++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic fill_src(input logic [31:0] src, input int n, input bit pattern);
        for (int i = 0; i < n; i++)
            mem[src + 32'(4 * i)] = pattern ? 32'(8'h11 * (i + 1)) : $urandom;
    endtask

    task automatic set_stalls(input bit rnd);
        for (int i = 0; i < 64; i++) begin
            addr_stall[i] = (rnd && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            data_stall[i] = (rnd && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        end
    endtask

    // Copy ln words; abort_word: word whose RD_A sees abort rise; err_word: read that errors.
    task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                            input int ln, input int abort_word, input int err_word,
                            input bit busy_start);
        logic [31:0] sv [64];
        int          n;
        bit          exp_err;
        clear_slave();
        exp_err  = (err_word >= 0 && err_word < ln);
        err_xfer = exp_err ? 2 * err_word : -1;
        n = ln;
        if (exp_err) n = err_word;
        else if (abort_word >= 0 && abort_word + 1 < ln) n = abort_word + 1;
        for (int i = 0; i < ln; i++) begin
            sv[i] = mem[src + 32'(4 * i)];
            mem.delete(dst + 32'(4 * i));
        end
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(src + 32'(4 * i)); exp_wr_q.push_back(1'b0);
            exp_addr_q.push_back(dst + 32'(4 * i)); exp_wr_q.push_back(1'b1);
        end
        if (exp_err) begin
            exp_addr_q.push_back(src + 32'(4 * n)); exp_wr_q.push_back(1'b0);
        end
        src_addr = src | 32'($urandom_range(0, 3));
        dst_addr = dst | 32'($urandom_range(0, 3));
        len      = 16'(ln);
        start    = 1'b1;
        cyc      = 0;
        cycle();
        start    = 1'b0;
        src_addr = $urandom;
        dst_addr = $urandom;
        len      = 16'($urandom);
        chk({name, "_busy_c1"}, 32'(busy), 32'd1);
        chk({name, "_err_clr"}, 32'(err), 32'd0);
        chk({name, "_wl_c1"}, 32'(words_left), 32'(ln));
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            if (abort_word >= 0 && HTRANS == 2'b10 && HWRITE == 1'b0 &&
                HADDR == src + 32'(4 * abort_word)) abort = 1'b1;
            start = busy_start && (cyc == 6);
            cycle();
        end
        start = 1'b0;
        cycle();
        abort = 1'b0;
        cycle();
        chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        if (!exp_err)
            chk({name, "_done_cycle"}, 32'(done_cyc),
                (ln == 0) ? 32'd2 : 32'(4 * n + 1 + stall_total));
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_words_left"}, 32'(words_left), 32'(ln - n));
        chk({name, "_xfers_left"}, 32'(exp_addr_q.size()), 32'd0);
        for (int i = 0; i < n; i++)
            chk({name, "_dst_word"}, rd_mem(dst + 32'(4 * i)), sv[i]);
        if (n < ln)
            chk({name, "_dst_untouched"}, 32'(mem.exists(dst + 32'(4 * n))), 32'd0);
    endtask

    initial begin
        logic [31:0] s, d;
        int          l, a;
        HRESETn  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        HRDATA   = '0;
        HREADY   = 1'b1;
        HRESP    = 1'b0;
        clear_slave();
        #12;
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_status", {29'd0, busy, done, err}, 32'd0);
        chk("rst_words_left", 32'(words_left), 32'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        chk("const_bus", {20'd0, HSIZE, HBURST, HMASTLOCK, HPROT, 1'b0}, 32'h0000_0406);

        set_stalls(0);
        fill_src(32'h2000_0000, 3, 1);
        run_copy("basic", 32'h2000_0000, 32'hBF40_0000, 3, -1, -1, 0);
        run_copy("len0", 32'h2000_0100, 32'hBF40_0100, 0, -1, -1, 0);

        set_stalls(0);
        addr_stall[0] = 3;
        data_stall[1] = 2;
        fill_src(32'h2000_0200, 2, 0);
        run_copy("stall", 32'h2000_0200, 32'hBF40_0200, 2, -1, -1, 0);

        set_stalls(0);
        fill_src(32'h2000_0300, 4, 0);
        run_copy("error", 32'h2000_0300, 32'hBF40_0300, 4, -1, 1, 0);
        fill_src(32'h2000_0400, 5, 0);
        run_copy("abort", 32'h2000_0400, 32'hBF40_0400, 5, 1, -1, 1);
        fill_src(32'h2000_0500, 3, 0);
        run_copy("abort_last", 32'h2000_0500, 32'hBF40_0500, 3, 2, -1, 0);
        fill_src(32'hFFFF_FFF8, 3, 0);
        run_copy("wrap", 32'hFFFF_FFF8, 32'h4000_0000, 3, -1, -1, 0);

        for (int r = 0; r < 6; r++) begin
            set_stalls(1);
            s = (32'($urandom) & 32'h0FFF_FFFC) | 32'h1000_0000;
            d = (32'($urandom) & 32'h0FFF_FFFC) | 32'h8000_0000;
            l = $urandom_range(1, 6);
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, l - 1) : -1;
            fill_src(s, l, 0);
            run_copy("random", s, d, l, a, -1, r[0]);
        end

        // Reset during the first write address phase.
        set_stalls(0);
        clear_slave();
        err_xfer = -1;
        fill_src(32'h2000_0600, 3, 0);
        exp_addr_q.push_back(32'h2000_0600); exp_wr_q.push_back(1'b0);
        exp_addr_q.push_back(32'hBF40_0600); exp_wr_q.push_back(1'b1);
        src_addr = 32'h2000_0600;
        dst_addr = 32'hBF40_0600;
        len      = 16'd3;
        start    = 1'b1;
        cyc      = 0;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 20 && !(HTRANS == 2'b10 && HWRITE == 1'b1); k++) cycle();
        chk("rst_seen_wr_a", {30'd0, HTRANS, HWRITE} & 32'h7, 32'h5);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_haddr", HADDR, 32'd0);
        chk("arst_htrans", 32'(HTRANS), 32'd0);
        chk("arst_hwrite", 32'(HWRITE), 32'd0);
        chk("arst_hwdata", HWDATA, 32'd0);
        chk("arst_status", {29'd0, busy, done, err}, 32'd0);
        chk("arst_words_left", 32'(words_left), 32'd0);
        clear_slave();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("post_rst_htrans", 32'(HTRANS), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        fill_src(32'h2000_0700, 1, 0);
        run_copy("after_rst", 32'h2000_0700, 32'hBF40_0700, 1, -1, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_dma_master.md
Name: mfp_ahb_dma_master

Overview:
Single-channel AHB-lite bus master (initiator) that copies a block of 32-bit words from a source address to a destination address. Typical use is SRAM or program RAM to VRAM. It drives the master side of the same AHB-lite bus the interconnect decodes, and issues only single NONSEQ word transfers. Software-visible control is a simple start/len/src/dst port set, wrapped later by a GPIO-style register slave.

Parameters:
LEN_W, 16, width of the word-count field; max transfer is 2^LEN_W-1 words.

Ports:
HCLK  input  1  bus clock; all logic on rising edge
HRESETn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; latches src_addr/dst_addr/len when idle
src_addr  input  32  source byte address; bits[1:0] ignored (forced 00)
dst_addr  input  32  destination byte address; bits[1:0] ignored
len  input  LEN_W  number of words to copy
abort  input  1  level; stops at next word boundary
HADDR  output  32  bus address
HTRANS  output  2  00 IDLE / 10 NONSEQ only
HWRITE  output  1  1 = write transfer
HSIZE  output  3  constant 010 (word)
HBURST  output  3  constant 000 (SINGLE)
HMASTLOCK  output  1  constant 0
HPROT  output  4  constant 0011 (data, privileged)
HWDATA  output  32  write data, valid in write data phase
HRDATA  input  32  read data from interconnect mux
HREADY  input  1  transfer complete / address accepted
HRESP  input  1  1 = ERROR response
busy  output  1  high from cycle after accepted start until DONE/ERR exit
done  output  1  one-cycle pulse on completion, abort, or error
err  output  1  sticky; set on HRESP error; cleared by next accepted start
words_left  output  LEN_W  remaining word count

Behaviour:
- Reset values: HADDR=0, HTRANS=00, HWRITE=0, HWDATA=0, busy=0, done=0, err=0, words_left=0, state=IDLE. All bus outputs are registered.
- States: IDLE, RD_A, RD_D, WR_A, WR_D, FIN.
- IDLE: HTRANS=00. On start, latch src/dst (low 2 bits cleared) and len, clear err, and set busy.
  - If len==0, go to FIN with no bus traffic.
  - Otherwise go to RD_A.
- RD_A: HTRANS=10, HWRITE=0, HADDR=src. Hold until HREADY=1 is sampled, then go to RD_D.
- RD_D: HTRANS=00. When HREADY=1 and HRESP=0, capture HRDATA into the word buffer and go to WR_A.
- WR_A: HTRANS=10, HWRITE=1, HADDR=dst. On HREADY=1, go to WR_D and drive HWDATA=buffer.
- WR_D: HTRANS=00, and HWDATA holds. On HREADY=1 and HRESP=0:
  - src+=4, dst+=4, words_left-=1.
  - If words_left becomes 0 or abort=1, go to FIN. Otherwise go to RD_A.
- FIN: pulse done for exactly one cycle, clear busy, return to IDLE.
- Error: HRESP=1 sampled in RD_D or WR_D (either cycle of the two-cycle response) sets err, skips the remaining words, and goes to FIN. The master never issues NONSEQ during an error response.
- Throughput with HREADY tied high: 4 cycles per word.
  - Start pulse at cycle 0 → first NONSEQ at cycle 1.
  - done at cycle 4N+1 for N words.
- Stalls: HREADY=0 holds the current state and all outputs stable, so HADDR/HTRANS/HWDATA do not change while a phase is extended.
- Address arithmetic is modulo 2^32 and wraps 0xFFFFFFFC → 0x00000000 silently.
- start while busy is ignored; latched values are unchanged.
- abort is only honoured at the end of a completed WR_D; a read already captured is always written.
- abort together with the last word gives the normal completion, with err=0.
- Asynchronous reset mid-transfer returns immediately to reset values. The in-flight transfer is abandoned, and the slave sees HTRANS=00 from then on.

Test Plan:
- Copy with HREADY=1, src=0x20000000 (model memory 0x11,0x22,0x33), dst=0xBF400000, len=3 → 3 read/write pairs with addresses +4 each; dst memory = 0x11,0x22,0x33; done pulse exactly at cycle 13 after start; busy low afterwards; words_left=0.
- len=0 start → no NONSEQ on HTRANS; done pulse 2 cycles after start; err=0.
- len=2 with HREADY=0 for 3 cycles during RD_A and 2 cycles during WR_D → HADDR/HTRANS/HWDATA stable across stalls; data correct; done at cycle 9+5=14.
- len=4, slave returns HRESP=1 (two-cycle, HREADY 0 then 1) on the second read → only 1 word written; err=1; done pulse; a new start clears err.
- len=5, abort raised during the second RD_A → exactly 2 words written; words_left=3; err=0; a start pulse while busy has no effect.
- HRESETn asserted during WR_A of word 1 → all outputs 0 asynchronously; after release the block stays in IDLE until the next start.
